vote_entry_fsm: RTL and testbench

- Keypad-side front end of the ballot box. Collects four BCD digits from switch and button inputs, then waits for confirm.
- Produces the estado and d1..d4 bus that the display path reads. On a valid confirm, emits a one-cycle vote strobe with the decoded candidate index for the tally counters.
- Sits between the debounced/synchronised board inputs and the display and tally blocks.

---
 rtl/vote_entry_fsm.sv | 126 ++++++++++++
 tb/tb_vote_entry_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_entry_fsm.sv
// Keypad-side entry FSM of the ballot box.
// Collects four BCD digits, waits for confirm, emits a vote strobe.
module vote_entry_fsm #(
  parameter logic [15:0] COD0 = 16'h1301,
  parameter logic [15:0] COD1 = 16'h2202,
  parameter logic [15:0] COD2 = 16'h3303,
  parameter logic [15:0] COD3 = 16'h4404
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       finish,
  input  logic [3:0] digitIn,
  input  logic       btnDigito,
  input  logic       btnConfirma,
  input  logic       btnCorrige,
  output logic [2:0] estado,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic       voto,
  output logic [2:0] escolhaCandidato
);

  localparam logic [2:0] S_DIG1 = 3'b000;
  localparam logic [2:0] S_DIG2 = 3'b001;
  localparam logic [2:0] S_DIG3 = 3'b010;
  localparam logic [2:0] S_DIG4 = 3'b011;
  localparam logic [2:0] S_CONF = 3'b100;
  localparam logic [2:0] S_RST  = 3'b111;

  localparam logic [3:0] BLANK = 4'd10;

  logic       prev_dig;
  logic       prev_conf;
  logic       prev_cor;
  logic       p_dig;
  logic       p_conf;
  logic       p_cor;
  logic       dig_ok;
  logic [15:0] code;
  logic [2:0] cand;

  // Previous samples start high so a button held through reset is no press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_dig  <= 1'b1;
      prev_conf <= 1'b1;
      prev_cor  <= 1'b1;
    end else begin
      prev_dig  <= btnDigito;
      prev_conf <= btnConfirma;
      prev_cor  <= btnCorrige;
    end
  end

  // Rising-edge press detect and candidate decode of the entered code.
  always_comb begin
    p_dig  = btnDigito & ~prev_dig;
    p_conf = btnConfirma & ~prev_conf;
    p_cor  = btnCorrige & ~prev_cor;
    dig_ok = (digitIn <= 4'd9);
    code   = {d1, d2, d3, d4};
    cand   = 3'b100;
    unique case (1'b1)
      (code == COD0): cand = 3'b000;
      (code == COD1): cand = 3'b001;
      (code == COD2): cand = 3'b010;
      (code == COD3): cand = 3'b011;
      default:        cand = 3'b100;
    endcase
  end

  // Entry state machine; corrige beats confirm beats digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= S_DIG1;
      d1               <= BLANK;
      d2               <= BLANK;
      d3               <= BLANK;
      d4               <= BLANK;
      voto             <= 1'b0;
      escolhaCandidato <= 3'b000;
    end else begin
      voto <= 1'b0;
      if (finish) begin
        estado <= S_DIG1;
        d1     <= BLANK;
        d2     <= BLANK;
        d3     <= BLANK;
        d4     <= BLANK;
      end else begin
        case (estado)
          S_DIG1, S_DIG2, S_DIG3, S_DIG4: begin
            if (p_cor) begin
              estado <= S_RST;
            end else if (!p_conf && p_dig && dig_ok) begin
              if (estado == S_DIG1)      d1 <= digitIn;
              else if (estado == S_DIG2) d2 <= digitIn;
              else if (estado == S_DIG3) d3 <= digitIn;
              else                       d4 <= digitIn;
              estado <= estado + 3'd1;
            end
          end
          S_CONF: begin
            if (p_cor) begin
              estado <= S_RST;
            end else if (p_conf) begin
              voto             <= 1'b1;
              escolhaCandidato <= cand;
              estado           <= S_RST;
            end
          end
          default: begin
            estado <= S_DIG1;
            d1     <= BLANK;
            d2     <= BLANK;
            d3     <= BLANK;
            d4     <= BLANK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vote_entry_fsm.sv
// Bench for vote_entry_fsm.
// Votes are scored through an expected-candidate queue.
module tb_vote_entry_fsm;

  logic       clk;
  logic       rst_n;
  logic       finish;
  logic [3:0] digitIn;
  logic       btnDigito;
  logic       btnConfirma;
  logic       btnCorrige;
  logic [2:0] estado;
  logic [3:0] d1, d2, d3, d4;
  logic       voto;
  logic [2:0] esc;

  int n_tests;
  int n_fail;
  int exp_q[$];
  logic prev_voto;
  logic [2:0] last_esc;

  vote_entry_fsm dut (
    .clock(clk),
    .reset(rst_n),
    .finish(finish),
    .digitIn(digitIn),
    .btnDigito(btnDigito),
    .btnConfirma(btnConfirma),
    .btnCorrige(btnCorrige),
    .estado(estado),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .d4(d4),
    .voto(voto),
    .escolhaCandidato(esc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vote scoreboard: each strobe pops one expected candidate.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_esc  = 3'b000;
      prev_voto = 1'b0;
    end else begin
      if (voto === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_voto got esc=%0d required no vote", esc);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (esc !== 3'(e)) begin
            n_fail++;
            $display("FAIL vote_cand got %0d required %0d", esc, e);
          end
        end
        if (prev_voto === 1'b1) begin
          n_fail++;
          $display("FAIL voto_twice got 1 required 0");
        end
        last_esc = esc;
      end else if (esc !== last_esc) begin
        n_tests++;
        n_fail++;
        $display("FAIL esc_hold got %0d required %0d", esc, last_esc);
      end
      prev_voto = voto;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 digit, 1 confirm, 2 corrige; returns one negedge after rise
  task automatic pulse(input int which, input logic [3:0] v);
    @(negedge clk);
    digitIn = v;
    if (which == 0) btnDigito = 1'b1;
    if (which == 1) btnConfirma = 1'b1;
    if (which == 2) btnCorrige = 1'b1;
    @(negedge clk);
    btnDigito   = 1'b0;
    btnConfirma = 1'b0;
    btnCorrige  = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = c[15-4*i -: 4];
      pulse(0, v);
      idle(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btnDigito = 1'b1;
    digitIn = 4'd5;
    idle(3);
    rst_n = 1'b1;
    n_tests++;
    if ({estado, voto, esc} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b required 0", {estado, voto, esc});
    end
    n_tests++;
    if ({d1, d2, d3, d4} !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL reset_digits got %h required aaaa", {d1, d2, d3, d4});
    end
    idle(2);
    n_tests++;
    if (estado !== 3'b000) begin
      n_fail++;
      $display("FAIL held_through_reset got %b required 000", estado);
    end
    btnDigito = 1'b0;
    idle(2);
  endtask

  task automatic test_vote_arthur;
    logic [15:0] c;
    c = 16'h1301;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      logic [3:0] got;
      v = c[15-4*i -: 4];
      pulse(0, v);
      got = (i == 0) ? d1 : (i == 1) ? d2 : (i == 2) ? d3 : d4;
      n_tests++;
      if (estado !== 3'(i + 1) || got !== v) begin
        n_fail++;
        $display("FAIL step%0d got st=%b d=%0d required st=%0d d=%0d",
                 i, estado, got, i + 1, v);
      end
      idle(3);
    end
    exp_q.push_back(0);
    pulse(1, 4'd0);
    n_tests++;
    if (voto !== 1'b1 || estado !== 3'b111) begin
      n_fail++;
      $display("FAIL arthur_confirm got voto=%b st=%b required 1 111",
               voto, estado);
    end
    idle(1);
    n_tests++;
    if (estado !== 3'b000 || voto !== 1'b0 || {d1, d2, d3, d4} !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL arthur_after got st=%b v=%b d=%h required 000 0 aaaa",
               estado, voto, {d1, d2, d3, d4});
    end
  endtask

  task automatic test_nulo;
    enter4(16'h9999);
    exp_q.push_back(4);
    pulse(1, 4'd0);
    idle(1);
    n_tests++;
    if (estado !== 3'b000) begin
      n_fail++;
      $display("FAIL nulo_after got %b required 000", estado);
    end
  endtask

  task automatic test_corrige;
    pulse(0, 4'd4);
    pulse(0, 4'd4);
    pulse(2, 4'd0);
    n_tests++;
    if (estado !== 3'b111 || voto !== 1'b0) begin
      n_fail++;
      $display("FAIL corrige got st=%b v=%b required 111 0", estado, voto);
    end
    idle(1);
    n_tests++;
    if (estado !== 3'b000 || {d1, d2, d3, d4} !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL corrige_clear got st=%b d=%h required 000 aaaa",
               estado, {d1, d2, d3, d4});
    end
    enter4(16'h4404);
    exp_q.push_back(3);
    pulse(1, 4'd0);
    idle(1);
  endtask

  task automatic test_hold_and_ignore;
    @(negedge clk);
    digitIn = 4'd5;
    btnDigito = 1'b1;
    idle(20);
    btnDigito = 1'b0;
    n_tests++;
    if (estado !== 3'b001 || {d1, d2, d3, d4} !== 16'h5AAA) begin
      n_fail++;
      $display("FAIL hold got st=%b d=%h required 001 5aaa",
               estado, {d1, d2, d3, d4});
    end
    pulse(0, 4'd12);
    n_tests++;
    if (estado !== 3'b001 || {d1, d2, d3, d4} !== 16'h5AAA) begin
      n_fail++;
      $display("FAIL bad_digit got st=%b d=%h required 001 5aaa",
               estado, {d1, d2, d3, d4});
    end
    pulse(1, 4'd0);
    n_tests++;
    if (estado !== 3'b001 || voto !== 1'b0) begin
      n_fail++;
      $display("FAIL early_confirm got st=%b v=%b required 001 0",
               estado, voto);
    end
    pulse(2, 4'd0);
    idle(1);
  endtask

  task automatic test_same_cycle;
    enter4(16'h2202);
    @(negedge clk);
    btnCorrige = 1'b1;
    btnConfirma = 1'b1;
    @(negedge clk);
    btnCorrige = 1'b0;
    btnConfirma = 1'b0;
    n_tests++;
    if (estado !== 3'b111 || voto !== 1'b0 || esc !== 3'b011) begin
      n_fail++;
      $display("FAIL cor_conf got st=%b v=%b esc=%0d required 111 0 3",
               estado, voto, esc);
    end
    idle(1);
    enter4(16'h2202);
    pulse(0, 4'd7);
    n_tests++;
    if (estado !== 3'b100 || d4 !== 4'd2) begin
      n_fail++;
      $display("FAIL fifth_digit got st=%b d4=%0d required 100 2",
               estado, d4);
    end
    exp_q.push_back(1);
    pulse(1, 4'd0);
    idle(1);
  endtask

  task automatic test_finish;
    pulse(0, 4'd1);
    pulse(0, 4'd3);
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    n_tests++;
    if (estado !== 3'b000 || voto !== 1'b0 || {d1, d2, d3, d4} !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL finish got st=%b v=%b d=%h required 000 0 aaaa",
               estado, voto, {d1, d2, d3, d4});
    end
    pulse(0, 4'd5);
    pulse(1, 4'd0);
    n_tests++;
    if (estado !== 3'b000 || d1 !== 4'd10) begin
      n_fail++;
      $display("FAIL finish_frozen got st=%b d1=%0d required 000 10",
               estado, d1);
    end
    @(negedge clk);
    finish = 1'b0;
    idle(1);
    pulse(0, 4'd8);
    n_tests++;
    if (estado !== 3'b001 || d1 !== 4'd8) begin
      n_fail++;
      $display("FAIL finish_resume got st=%b d1=%0d required 001 8",
               estado, d1);
    end
    pulse(2, 4'd0);
    idle(1);
  endtask

  task automatic test_reset_in_vote;
    enter4(16'h1301);
    @(negedge clk);
    btnConfirma = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    btnConfirma = 1'b0;
    n_tests++;
    if (voto !== 1'b0 || estado !== 3'b000 || esc !== 3'b000
        || {d1, d2, d3, d4} !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL reset_in_vote got v=%b st=%b esc=%0d d=%h required 0 000 0 aaaa",
               voto, estado, esc, {d1, d2, d3, d4});
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    n_tests++;
    if (estado !== 3'b000 || voto !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset got st=%b v=%b required 000 0", estado, voto);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    prev_voto = 1'b0;
    last_esc = 3'b000;
    finish = 1'b0;
    digitIn = 4'd0;
    btnDigito = 1'b0;
    btnConfirma = 1'b0;
    btnCorrige = 1'b0;
    rst_n = 1'b0;
    test_reset;
    test_vote_arthur;
    test_nulo;
    test_corrige;
    test_hold_and_ignore;
    test_same_cycle;
    test_finish;
    test_reset_in_vote;
    idle(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_votes got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
